// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory/writeback stage and its neighbours.
// Contents: request FSM state encoding, writeback source select codes,
// opcode constants shared with the pipeline register, and an alignment helper.
package mem_wb_stage_pkg;

  // Request FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Writeback source select (inMulSel)
  localparam logic [1:0] MUL_ALU  = 2'd0;
  localparam logic [1:0] MUL_LOAD = 2'd1;
  localparam logic [1:0] MUL_PC   = 2'd2;
  localparam logic [1:0] MUL_ZERO = 2'd3;

  // Opcode constants shared with the execute/memory pipeline register
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_BR  = 6'h04;
  localparam logic [5:0] OP_JAL = 6'h03;

  // Word accesses must have the two low address bits clear
  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer.
// Issues the memory request, stalls the pipeline while the memory is not
// ready, and gives up after TIMEOUT_CYCLES cycles in WAIT.
// Ports:
//   clk, reset   - clock, async active-high reset
//   mem_op       - current instruction is a load or store
//   addr_lo      - low two bits of the access address
//   dmem_ready   - memory accepts/completes the request this cycle
//   req          - memory request valid (combinational)
//   stall        - pipeline must hold (combinational)
//   timeout      - request abandoned this cycle; instruction retires faulted
//   misalign     - misaligned access; no request, instruction retires faulted
module mem_req_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_op,
  input  logic [1:0] addr_lo,
  input  logic       dmem_ready,
  output logic       req,
  output logic       stall,
  output logic       timeout,
  output logic       misalign
);

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

  mem_state_t state_r;
  mem_state_t state_next_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_next_s;
  logic       req_s;
  logic       stall_s;
  logic       timeout_s;
  logic       misalign_s;

  // State and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state, counter and request/stall decode
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    req_s        = 1'b0;
    timeout_s    = 1'b0;
    misalign_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_op) begin
          if (word_aligned(addr_lo)) begin
            req_s = 1'b1;
          end else begin
            misalign_s = 1'b1;
          end
        end else begin
          req_s = 1'b0;
        end
        cnt_next_s = 5'd0;
        if (req_s && !dmem_ready) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (dmem_ready) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 5'd0;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_IDLE;
          cnt_next_s   = 5'd0;
        end else begin
          state_next_s = ST_WAIT;
          cnt_next_s   = cnt_r + 5'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 5'd0;
      end
    endcase
    // The timeout cycle is not a stall: it is the edge that retires the
    // abandoned instruction.
    stall_s = req_s && !dmem_ready && !timeout_s;
  end

  // Reset kills the request and stall immediately, without waiting for a clock
  assign req      = req_s && !reset;
  assign stall    = stall_s && !reset;
  assign timeout  = timeout_s && !reset;
  assign misalign = misalign_s && !reset;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and writeback stage.
// Drives the data-memory request from the execute/memory pipeline register,
// stalls upstream while memory is busy, and registers the writeback
// (index, enable, data) to the register file. Faulted accesses (misaligned
// or timed out) retire without a register write and set a sticky memFault.
// Ports:
//   clk, reset                       - clock, async active-high reset
//   inWrtIndex/inRegWrEn/inMulSel    - writeback control from upstream
//   inAluOut/inData2Out/inPC         - ALU result/address, store data, link PC
//   inIsLoad/inIsStore               - memory operation flags
//   dmemReq/dmemWrEn/dmemAddr/dmemWrData, dmemReady/dmemRdData - memory port
//   memStall                         - upstream hold
//   outWrtIndex/outRegWrEn/outWbData - registered writeback
//   memFault                         - sticky error flag
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE    = 32'd0,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  inWrtIndex,
  input  logic        inRegWrEn,
  input  logic [1:0]  inMulSel,
  input  logic [31:0] inAluOut,
  input  logic [31:0] inData2Out,
  input  logic [31:0] inPC,
  input  logic        inIsLoad,
  input  logic        inIsStore,
  output logic        dmemReq,
  output logic        dmemWrEn,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWrData,
  input  logic        dmemReady,
  input  logic [31:0] dmemRdData,
  output logic        memStall,
  output logic [3:0]  outWrtIndex,
  output logic        outRegWrEn,
  output logic [31:0] outWbData,
  output logic        memFault
);

  logic        stall_s;
  logic        timeout_s;
  logic        misalign_s;
  logic [31:0] wb_data_s;
  logic [3:0]  out_wrt_index_r;
  logic        out_reg_wr_en_r;
  logic [31:0] out_wb_data_r;
  logic        mem_fault_r;

  mem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_req_fsm (
    .clk       (clk),
    .reset     (reset),
    .mem_op    (inIsLoad | inIsStore),
    .addr_lo   (inAluOut[1:0]),
    .dmem_ready(dmemReady),
    .req       (dmemReq),
    .stall     (stall_s),
    .timeout   (timeout_s),
    .misalign  (misalign_s)
  );

  assign memStall   = stall_s;
  assign dmemWrEn   = inIsStore;
  assign dmemAddr   = inAluOut;
  assign dmemWrData = inData2Out;

  // Writeback source select; load data comes straight from the memory port
  always_comb begin
    wb_data_s = 32'd0;
    case (inMulSel)
      MUL_ALU:  wb_data_s = inAluOut;
      MUL_LOAD: wb_data_s = dmemRdData;
      MUL_PC:   wb_data_s = inPC;
      MUL_ZERO: wb_data_s = 32'd0;
      default:  wb_data_s = 32'd0;
    endcase
  end

  // Writeback registers: bubble on stall, retire otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wrt_index_r <= RESET_VALUE[3:0];
      out_reg_wr_en_r <= 1'b0;
      out_wb_data_r   <= RESET_VALUE;
    end else if (stall_s) begin
      out_reg_wr_en_r <= 1'b0;
    end else begin
      out_wrt_index_r <= inWrtIndex;
      out_reg_wr_en_r <= inRegWrEn && !timeout_s && !misalign_s;
      out_wb_data_r   <= wb_data_s;
    end
  end

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_fault_r <= 1'b0;
    end else if (timeout_s || misalign_s) begin
      mem_fault_r <= 1'b1;
    end
  end

  assign outWrtIndex = out_wrt_index_r;
  assign outRegWrEn  = out_reg_wr_en_r;
  assign outWbData   = out_wb_data_r;
  assign memFault    = mem_fault_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a table of single-cycle instructions
// followed by hand-written multi-cycle sequences (wait, timeout, reset in WAIT).
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  inWrtIndex;
  logic        inRegWrEn;
  logic [1:0]  inMulSel;
  logic [31:0] inAluOut;
  logic [31:0] inData2Out;
  logic [31:0] inPC;
  logic        inIsLoad;
  logic        inIsStore;
  logic        dmemReq;
  logic        dmemWrEn;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWrData;
  logic        dmemReady;
  logic [31:0] dmemRdData;
  logic        memStall;
  logic [3:0]  outWrtIndex;
  logic        outRegWrEn;
  logic [31:0] outWbData;
  logic        memFault;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .inWrtIndex (inWrtIndex),
    .inRegWrEn  (inRegWrEn),
    .inMulSel   (inMulSel),
    .inAluOut   (inAluOut),
    .inData2Out (inData2Out),
    .inPC       (inPC),
    .inIsLoad   (inIsLoad),
    .inIsStore  (inIsStore),
    .dmemReq    (dmemReq),
    .dmemWrEn   (dmemWrEn),
    .dmemAddr   (dmemAddr),
    .dmemWrData (dmemWrData),
    .dmemReady  (dmemReady),
    .dmemRdData (dmemRdData),
    .memStall   (memStall),
    .outWrtIndex(outWrtIndex),
    .outRegWrEn (outRegWrEn),
    .outWbData  (outWbData),
    .memFault   (memFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [31:0] pc;
    logic        ld;
    logic        st;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic        e_stall;
    logic [3:0]  e_idx;
    logic        e_en;
    logic [31:0] e_data;
    logic        chk_data;
    logic        e_fault;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] idx, input logic en, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
                       input logic ld, input logic st, input logic rdy, input logic [31:0] rd);
    inWrtIndex = idx; inRegWrEn = en; inMulSel = sel; inAluOut = alu;
    inData2Out = d2; inPC = pc; inIsLoad = ld; inIsStore = st;
    dmemReady = rdy; dmemRdData = rd;
  endtask

  task automatic idle_inputs();
    drive(4'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();

    //                idx   en    sel   alu            d2             pc             ld    st    rdy   rd             req   stall e_idx e_en  e_data         chkd  fault
    vecs[0] = '{4'd5,  1'b1, 2'd0, 32'h0000_1234, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b0};
    vecs[1] = '{4'd7,  1'b0, 2'd0, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'd7,  1'b0, 32'h0000_0020, 1'b1, 1'b0};
    vecs[2] = '{4'd3,  1'b1, 2'd1, 32'h0000_0040, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd3,  1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[3] = '{4'd15, 1'b1, 2'd2, 32'h0000_0055, 32'h0,         32'h0000_1008, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd15, 1'b1, 32'h0000_1008, 1'b1, 1'b0};
    vecs[4] = '{4'd9,  1'b1, 2'd3, 32'h0000_FFFF, 32'h0,         32'h0000_2000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd9,  1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{4'd2,  1'b1, 2'd0, 32'h0000_0024, 32'h1357_9BDF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'd2,  1'b1, 32'h0000_0024, 1'b1, 1'b0};
    vecs[6] = '{4'd4,  1'b0, 2'd0, 32'h0000_0077, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd4,  1'b0, 32'h0000_0077, 1'b1, 1'b0};
    vecs[7] = '{4'd6,  1'b1, 2'd1, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 4'd6,  1'b0, 32'h0,         1'b0, 1'b1};
    vecs[8] = '{4'd1,  1'b1, 2'd0, 32'h0000_ABCD, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd1,  1'b1, 32'h0000_ABCD, 1'b1, 1'b1};
    vecs[9] = '{4'd11, 1'b1, 2'd0, 32'h0000_0021, 32'h0BAD_0BAD, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 4'd11, 1'b0, 32'h0,         1'b0, 1'b1};

    // Reset state, checked while reset is held
    #12;
    chk("rst_req", {31'd0, dmemReq}, 32'd0);
    chk("rst_stall", {31'd0, memStall}, 32'd0);
    chk("rst_en", {31'd0, outRegWrEn}, 32'd0);
    chk("rst_idx", {28'd0, outWrtIndex}, 32'd0);
    chk("rst_data", outWbData, 32'd0);
    chk("rst_fault", {31'd0, memFault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table of single-cycle instructions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].idx, vecs[i].en, vecs[i].sel, vecs[i].alu, vecs[i].d2, vecs[i].pc,
            vecs[i].ld, vecs[i].st, vecs[i].rdy, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, dmemReq}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_stall", i), {31'd0, memStall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_wren", i), {31'd0, dmemWrEn}, {31'd0, vecs[i].st});
      chk($sformatf("v%0d_addr", i), dmemAddr, vecs[i].alu);
      chk($sformatf("v%0d_wdata", i), dmemWrData, vecs[i].d2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_oidx", i), {28'd0, outWrtIndex}, {28'd0, vecs[i].e_idx});
      chk($sformatf("v%0d_oen", i), {31'd0, outRegWrEn}, {31'd0, vecs[i].e_en});
      if (vecs[i].chk_data) chk($sformatf("v%0d_odata", i), outWbData, vecs[i].e_data);
      chk($sformatf("v%0d_fault", i), {31'd0, memFault}, {31'd0, vecs[i].e_fault});
    end

    // Reset to clear the sticky fault
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst2_fault", {31'd0, memFault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU op that leaves a known value in the writeback registers
    drive(4'd5, 1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("alu_data", outWbData, 32'h0000_1234);

    // Load waiting three cycles for memory
    @(negedge clk);
    drive(4'd8, 1'b1, 2'd1, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ld_stall%0d", c), {31'd0, memStall}, 32'd1);
      chk($sformatf("ld_req%0d", c), {31'd0, dmemReq}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("ld_bubble%0d", c), {31'd0, outRegWrEn}, 32'd0);
      chk($sformatf("ld_hold_idx%0d", c), {28'd0, outWrtIndex}, 32'd5);
      chk($sformatf("ld_hold_data%0d", c), outWbData, 32'h0000_1234);
      @(negedge clk);
    end
    dmemReady = 1'b1;
    dmemRdData = 32'hCAFE_F00D;
    #1;
    chk("ld_done_stall", {31'd0, memStall}, 32'd0);
    chk("ld_done_req", {31'd0, dmemReq}, 32'd1);
    @(posedge clk);
    #1;
    chk("ld_idx", {28'd0, outWrtIndex}, 32'd8);
    chk("ld_en", {31'd0, outRegWrEn}, 32'd1);
    chk("ld_data", outWbData, 32'hCAFE_F00D);
    chk("ld_fault", {31'd0, memFault}, 32'd0);

    // Timeout: memory never ready
    @(negedge clk);
    drive(4'd10, 1'b1, 2'd1, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!memStall) break;
      n++;
      @(posedge clk);
      #1;
      chk($sformatf("to_bubble%0d", c), {31'd0, outRegWrEn}, 32'd0);
      @(negedge clk);
    end
    chk("to_stall_cycles", n, 32'd16);
    @(posedge clk);
    #1;
    chk("to_fault", {31'd0, memFault}, 32'd1);
    chk("to_en", {31'd0, outRegWrEn}, 32'd0);
    chk("to_idx", {28'd0, outWrtIndex}, 32'd10);
    // FSM back in IDLE: a plain ALU op goes straight through
    @(negedge clk);
    drive(4'd13, 1'b1, 2'd0, 32'h0000_0ACE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to_idle_req", {31'd0, dmemReq}, 32'd0);
    chk("to_idle_stall", {31'd0, memStall}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_next_data", outWbData, 32'h0000_0ACE);
    chk("to_next_en", {31'd0, outRegWrEn}, 32'd1);
    chk("to_fault_sticky", {31'd0, memFault}, 32'd1);

    // Reset in the middle of WAIT
    @(negedge clk);
    drive(4'd14, 1'b1, 2'd1, 32'h0000_0300, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rw_req_before", {31'd0, dmemReq}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_req", {31'd0, dmemReq}, 32'd0);
    chk("rw_stall", {31'd0, memStall}, 32'd0);
    chk("rw_en", {31'd0, outRegWrEn}, 32'd0);
    chk("rw_idx", {28'd0, outWrtIndex}, 32'd0);
    chk("rw_data", outWbData, 32'd0);
    chk("rw_fault", {31'd0, memFault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'd12, 1'b1, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rw_next_req", {31'd0, dmemReq}, 32'd0);
    @(posedge clk);
    #1;
    chk("rw_next_idx", {28'd0, outWrtIndex}, 32'd12);
    chk("rw_next_en", {31'd0, outRegWrEn}, 32'd1);
    chk("rw_next_data", outWbData, 32'h0000_0042);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
